// File: rtl/gb_timer_pkg.sv
// gb_timer_pkg
// Shared types and constants for the Game Boy DIV/TIMA/TMA/TAC timer.
//   timer_addr_t  : CPU register select (FF04..FF07 -> 0..3)
//   timer_state_t : TIMA overflow/reload sequencer states
//   TAC_BIT_IDX   : TAC[1:0] -> system counter bit that clocks TIMA
//   TAC_READ_MASK : unused TAC bits read back as ones
package gb_timer_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    TIMA = 2'd1,
    TMA  = 2'd2,
    TAC  = 2'd3
  } timer_addr_t;

  typedef enum logic {
    COUNT  = 1'b0,
    RELOAD = 1'b1
  } timer_state_t;

  // 00 -> 4096 Hz, 01 -> 262144 Hz, 10 -> 65536 Hz, 11 -> 16384 Hz
  localparam int unsigned TAC_BIT_IDX [4] = '{9, 3, 5, 7};

  localparam logic [7:0] TAC_READ_MASK = 8'hF8;

endpackage

// File: rtl/gb_timer_if.sv
// gb_timer_if
// CPU-side bus of the timer plus the T-cycle strobe from the clock divider.
//   tick_in     : T-cycle enable strobe, one clk wide
//   wr_en_in    : register write strobe, one clk wide
//   addr_in     : register select 0=DIV 1=TIMA 2=TMA 3=TAC
//   wr_data_in  : write data
//   rd_data_out : combinational read of the register at addr_in
//   irq_out     : timer interrupt request, one clk pulse
// master = bus/CPU side, slave = timer side.
interface gb_timer_if;
  logic       tick_in;
  logic       wr_en_in;
  logic [1:0] addr_in;
  logic [7:0] wr_data_in;
  logic [7:0] rd_data_out;
  logic       irq_out;

  modport master (
    output tick_in, wr_en_in, addr_in, wr_data_in,
    input  rd_data_out, irq_out
  );

  modport slave (
    input  tick_in, wr_en_in, addr_in, wr_data_in,
    output rd_data_out, irq_out
  );
endinterface

// File: rtl/gb_timer_edge_sel.sv
// tima_edge_sel
// Picks the system counter bit selected by TAC, gates it with the TAC enable
// and produces a one-clk inc_pulse on each falling edge of that gated bit.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   tac            : stored TAC[2:0]
//   sys_cnt        : free-running system counter
//   div_wr, tac_wr : DIV / TAC write strobes of this clk
//   inc_pulse      : TIMA increment request
// Build option GB_TIMER_GLITCH_EN: when defined, edges caused by DIV/TAC
// writes also increment TIMA (DMG behaviour); when undefined the edge history
// is cleared on those writes so only tick-driven edges count.
module tima_edge_sel #(
  parameter int SYS_CNT_WIDTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [2:0]               tac,
  input  logic [SYS_CNT_WIDTH-1:0] sys_cnt,
  input  logic                     div_wr,
  input  logic                     tac_wr,
  output logic                     inc_pulse
);
  import gb_timer_pkg::*;

  logic bit_sel;
  logic sel_p0;
  logic sel_nxt;
  logic sel_p1;

  always_comb begin
    case (tac[1:0])
      2'b00:   bit_sel = sys_cnt[TAC_BIT_IDX[0]];
      2'b01:   bit_sel = sys_cnt[TAC_BIT_IDX[1]];
      2'b10:   bit_sel = sys_cnt[TAC_BIT_IDX[2]];
      default: bit_sel = sys_cnt[TAC_BIT_IDX[3]];
    endcase
  end

  assign sel_p0 = tac[2] & bit_sel;

`ifdef GB_TIMER_GLITCH_EN
  logic unused_wr;
  assign unused_wr = div_wr ^ tac_wr;
  assign sel_nxt   = sel_p0;
`else
  // Forgetting the history on a write hides the write-induced edge.
  assign sel_nxt = (div_wr | tac_wr) ? 1'b0 : sel_p0;
`endif

  // stage p0 -> p1: edge history
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sel_p1 <= 1'b0;
    else        sel_p1 <= sel_nxt;
  end

  assign inc_pulse = sel_p1 & ~sel_p0;

endmodule

// File: rtl/gb_timer.sv
// gb_timer
// Game Boy DIV/TIMA/TMA/TAC timer. Counts T-cycle strobes in a system
// counter (DIV = upper 8 bits), increments TIMA on falling edges of the
// TAC-selected counter bit and, after TIMA overflows, waits RELOAD_DELAY
// ticks before reloading TIMA from TMA and pulsing irq_out.
// Ports:
//   clk_in : system clock
//   rst_in : asynchronous active-high reset
//   bus    : gb_timer_if.slave (tick, register write/read, irq)
// Build option GB_TIMER_GLITCH_EN: see tima_edge_sel.
module gb_timer #(
  parameter int SYS_CNT_WIDTH = 16,
  parameter int RELOAD_DELAY  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  gb_timer_if.slave   bus
);
  import gb_timer_pkg::*;

  localparam int WAIT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RELOAD_DELAY - 1);

  timer_addr_t                addr;
  logic                       div_wr, tima_wr, tma_wr, tac_wr;
  logic [SYS_CNT_WIDTH-1:0]   sys_cnt;
  logic [7:0]                 tima, tima_nxt;
  logic [7:0]                 tma, tma_eff;
  logic [2:0]                 tac;
  logic [WAIT_W-1:0]          wait_cnt, wait_nxt;
  timer_state_t               state, state_nxt;
  logic                       inc_pulse;
  logic                       irq;

  assign addr    = timer_addr_t'(bus.addr_in);
  assign div_wr  = bus.wr_en_in && (addr == DIV);
  assign tima_wr = bus.wr_en_in && (addr == TIMA);
  assign tma_wr  = bus.wr_en_in && (addr == TMA);
  assign tac_wr  = bus.wr_en_in && (addr == TAC);

  // A reload on the same clk as a TMA write picks up the new value.
  assign tma_eff = tma_wr ? bus.wr_data_in : tma;

  // stage p0: system counter and plain registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sys_cnt <= '0;
      tma     <= 8'h00;
      tac     <= 3'b000;
    end else begin
      if (div_wr)           sys_cnt <= '0;
      else if (bus.tick_in) sys_cnt <= sys_cnt + SYS_CNT_WIDTH'(1);
      if (tma_wr) tma <= bus.wr_data_in;
      if (tac_wr) tac <= bus.wr_data_in[2:0];
    end
  end

  tima_edge_sel #(
    .SYS_CNT_WIDTH(SYS_CNT_WIDTH)
  ) u_edge_sel (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .tac       (tac),
    .sys_cnt   (sys_cnt),
    .div_wr    (div_wr),
    .tac_wr    (tac_wr),
    .inc_pulse (inc_pulse)
  );

  always_comb begin
    state_nxt = state;
    tima_nxt  = tima;
    wait_nxt  = wait_cnt;
    irq       = 1'b0;
    case (state)
      COUNT: begin
        // A CPU write to TIMA beats a same-clk increment.
        if (tima_wr) begin
          tima_nxt = bus.wr_data_in;
        end else if (inc_pulse) begin
          if (tima == 8'hFF) begin
            tima_nxt  = 8'h00;
            wait_nxt  = '0;
            state_nxt = RELOAD;
          end else begin
            tima_nxt = tima + 8'd1;
          end
        end
      end
      RELOAD: begin
        // TIMA holds 0x00 here; increments are dropped.
        if (tima_wr) begin
          tima_nxt  = bus.wr_data_in;
          state_nxt = COUNT;
        end else if (bus.tick_in) begin
          if (wait_cnt == WAIT_LAST) begin
            tima_nxt  = tma_eff;
            irq       = 1'b1;
            state_nxt = COUNT;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      default: state_nxt = COUNT;
    endcase
  end

  // stage p0 -> p1: sequencer state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= COUNT;
      tima     <= 8'h00;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tima     <= tima_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign bus.irq_out = irq;

  always_comb begin
    bus.rd_data_out = 8'h00;
    case (addr)
      DIV:     bus.rd_data_out = sys_cnt[SYS_CNT_WIDTH-1 -: 8];
      TIMA:    bus.rd_data_out = tima;
      TMA:     bus.rd_data_out = tma;
      TAC:     bus.rd_data_out = TAC_READ_MASK | {5'b00000, tac};
      default: bus.rd_data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer
// Self-checking bench for gb_timer: register table, hand sequences for the
// multi-cycle corners, and random traffic against a behavioural model.
module tb_gb_timer;

  localparam int RD = 4;
  localparam logic [1:0] A_DIV = 2'd0, A_TIMA = 2'd1, A_TMA = 2'd2, A_TAC = 2'd3;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  gb_timer_if bus();

  gb_timer #(.SYS_CNT_WIDTH(16), .RELOAD_DELAY(RD)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int         m_sys;
  logic [7:0] m_tima, m_tma;
  logic [2:0] m_tac;
  bit         m_seen_hi;   // gated bit was high at the previous clk
  int         m_remain;    // ticks left before reload, 0 = not reloading
  int         idx_tbl [4] = '{9, 3, 5, 7};

  function automatic bit m_gated();
    return m_tac[2] && (((m_sys >> idx_tbl[m_tac[1:0]]) & 1) != 0);
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      A_DIV:   return 8'((m_sys >> 8) & 255);
      A_TIMA:  return m_tima;
      A_TMA:   return m_tma;
      default: return {5'b11111, m_tac};
    endcase
  endfunction

  function automatic bit m_irq(input bit t, input bit w, input logic [1:0] a);
    return (m_remain == 1) && t && !(w && a == A_TIMA);
  endfunction

  task automatic m_reset();
    m_sys = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_seen_hi = 0; m_remain = 0;
  endtask

  task automatic m_step(input bit t, input bit w, input logic [1:0] a, input logic [7:0] d);
    bit g, inc;
    logic [7:0] tma_new;
    g = m_gated();
    inc = m_seen_hi && !g;
    tma_new = (w && a == A_TMA) ? d : m_tma;
    if (w && a == A_TIMA) begin
      m_tima = d; m_remain = 0;
    end else if (m_remain > 0) begin
      if (t) begin
        if (m_remain == 1) begin m_tima = tma_new; m_remain = 0; end
        else m_remain = m_remain - 1;
      end
    end else if (inc) begin
      if (m_tima == 8'hFF) begin m_tima = 0; m_remain = RD; end
      else m_tima = m_tima + 8'd1;
    end
    if (w && a == A_DIV) m_sys = 0;
    else if (t) m_sys = (m_sys + 1) & 16'hFFFF;
    if (w && a == A_TAC) m_tac = d[2:0];
    m_tma = tma_new;
`ifdef GB_TIMER_GLITCH_EN
    m_seen_hi = g;
`else
    m_seen_hi = (w && (a == A_DIV || a == A_TAC)) ? 1'b0 : g;
`endif
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge; drives one clk, samples before the edge, ends at next negedge.
  task automatic cycle(input bit t, input bit w, input logic [1:0] a, input logic [7:0] d,
                       input bit do_chk, output logic [7:0] rd, output logic irq);
    bus.tick_in = t; bus.wr_en_in = w; bus.addr_in = a; bus.wr_data_in = d;
    #1;
    rd = bus.rd_data_out;
    irq = bus.irq_out;
    if (do_chk) begin
      chk("rand_rd", int'(rd), int'(m_read(a)));
      chk("rand_irq", int'(irq), int'(m_irq(t, w, a)));
    end
    @(posedge clk_in);
    m_step(t, w, a, d);
    @(negedge clk_in);
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] v);
    bus.tick_in = 0; bus.wr_en_in = 0; bus.addr_in = a;
    #1 v = bus.rd_data_out;
  endtask

  task automatic do_reset();
    bus.tick_in = 0; bus.wr_en_in = 0; bus.addr_in = 0; bus.wr_data_in = 0;
    rst_in = 1'b1;
    m_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] r; logic q;
    cycle(0, 1, a, d, 0, r, q);
  endtask

  task automatic ticks(input int n, input logic [1:0] a);
    logic [7:0] r; logic q;
    repeat (n) cycle(1, 0, a, 8'h00, 0, r, q);
  endtask

  typedef struct {
    string      name;
    bit         w;
    logic [1:0] a;
    logic [7:0] d;
    logic [1:0] ra;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] v, r;
    logic q;
    int first0, zeros, irqs, irq_at, rel_at;

    bus.tick_in = 0; bus.wr_en_in = 0; bus.addr_in = 0; bus.wr_data_in = 0;
    m_reset();
    @(negedge clk_in);
    do_reset();

    // reset state
    peek(A_DIV, v);  chk("rst_div", v, 8'h00);
    peek(A_TIMA, v); chk("rst_tima", v, 8'h00);
    peek(A_TMA, v);  chk("rst_tma", v, 8'h00);
    peek(A_TAC, v);  chk("rst_tac", v, 8'hF8);
    chk("rst_irq", bus.irq_out, 0);

    // register table
    tbl[0] = '{"tbl_idle_div", 0, A_DIV,  8'h00, A_DIV,  8'h00};
    tbl[1] = '{"tbl_tma",      1, A_TMA,  8'h5A, A_TMA,  8'h5A};
    tbl[2] = '{"tbl_tac_ff",   1, A_TAC,  8'hFF, A_TAC,  8'hFF};
    tbl[3] = '{"tbl_tac_02",   1, A_TAC,  8'h02, A_TAC,  8'hFA};
    tbl[4] = '{"tbl_tima",     1, A_TIMA, 8'h77, A_TIMA, 8'h77};
    tbl[5] = '{"tbl_div_clr",  1, A_DIV,  8'h12, A_DIV,  8'h00};
    tbl[6] = '{"tbl_tma_0",    1, A_TMA,  8'h00, A_TMA,  8'h00};
    tbl[7] = '{"tbl_tima_hold",0, A_TIMA, 8'h00, A_TIMA, 8'h77};
    for (int i = 0; i < 8; i++) begin
      cycle(0, tbl[i].w, tbl[i].a, tbl[i].d, 0, r, q);
      peek(tbl[i].ra, v);
      chk(tbl[i].name, v, tbl[i].exp);
    end

    // DIV rate and clear
    do_reset();
    ticks(512, A_DIV);
    peek(A_DIV, v); chk("div_512", v, 8'h02);
    wr(A_DIV, 8'hAB);
    peek(A_DIV, v); chk("div_clr", v, 8'h00);
    ticks(255, A_DIV);
    peek(A_DIV, v); chk("div_255", v, 8'h00);
    ticks(1, A_DIV);
    peek(A_DIV, v); chk("div_256", v, 8'h01);

    // TIMA increment rates
    do_reset();
    wr(A_TAC, 8'h05);
    ticks(160, A_TIMA);
    cycle(0, 0, A_TIMA, 0, 0, r, q);
    peek(A_TIMA, v); chk("tima_bit3", v, 8'd10);
    do_reset();
    wr(A_TAC, 8'h04);
    ticks(2048, A_TIMA);
    cycle(0, 0, A_TIMA, 0, 0, r, q);
    peek(A_TIMA, v); chk("tima_bit9", v, 8'd2);

    // overflow and reload
    do_reset();
    wr(A_TMA, 8'hF0); wr(A_TAC, 8'h05); wr(A_TIMA, 8'hFF);
    first0 = -1; zeros = 0; irqs = 0; irq_at = -1; rel_at = -1;
    for (int k = 1; k <= 30; k++) begin
      cycle(1, 0, A_TIMA, 0, 0, r, q);
      if (r == 8'h00) begin if (first0 < 0) first0 = k; zeros++; end
      if (q) begin irqs++; irq_at = k; end
      if (r == 8'hF0 && rel_at < 0) rel_at = k;
    end
    chk("ovf_first_zero", first0, 18);
    chk("ovf_zero_ticks", zeros, RD);
    chk("ovf_irq_count", irqs, 1);
    chk("ovf_irq_clk", irq_at, 21);
    chk("ovf_reload_clk", rel_at, 22);

    // cancel pending reload with a TIMA write
    do_reset();
    wr(A_TMA, 8'hF0); wr(A_TAC, 8'h05); wr(A_TIMA, 8'hFF);
    irqs = 0;
    for (int k = 1; k <= 18; k++) begin
      cycle(1, 0, A_TIMA, 0, 0, r, q);
      if (q) irqs++;
    end
    cycle(1, 1, A_TIMA, 8'h33, 0, r, q);
    if (q) irqs++;
    cycle(1, 0, A_TIMA, 0, 0, r, q);
    if (q) irqs++;
    chk("cancel_tima", r, 8'h33);
    for (int k = 21; k <= 40; k++) begin
      cycle(1, 0, A_TIMA, 0, 0, r, q);
      if (q) irqs++;
    end
    peek(A_TIMA, v);
    chk("cancel_next_inc", v, 8'h34);
    chk("cancel_no_irq", irqs, 0);

    // write-induced edge
    do_reset();
    wr(A_TAC, 8'h05);
    ticks(8, A_TIMA);
    cycle(0, 0, A_TIMA, 0, 0, r, q);
    wr(A_DIV, 8'h00);
    cycle(0, 0, A_TIMA, 0, 0, r, q);
    cycle(0, 0, A_TIMA, 0, 0, r, q);
    peek(A_TIMA, v);
`ifdef GB_TIMER_GLITCH_EN
    chk("glitch_div", v, 8'h01);
`else
    chk("glitch_div", v, 8'h00);
`endif

    // asynchronous reset mid-count
    do_reset();
    wr(A_TAC, 8'h05); wr(A_TIMA, 8'h10);
    ticks(100, A_TIMA);
    cycle(0, 0, A_TIMA, 0, 0, r, q);
    peek(A_TIMA, v); chk("pre_rst_tima", v, 8'h16);
    #2 rst_in = 1'b1;
    m_reset();
    peek(A_DIV, v);  chk("arst_div", v, 8'h00);
    peek(A_TIMA, v); chk("arst_tima", v, 8'h00);
    peek(A_TMA, v);  chk("arst_tma", v, 8'h00);
    peek(A_TAC, v);  chk("arst_tac", v, 8'hF8);
    chk("arst_irq", bus.irq_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit t, w;
      logic [1:0] a;
      logic [7:0] d;
      t = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 11) == 0);
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      if (w && a == A_TIMA && $urandom_range(0, 1) == 1) d = 8'hFC | d[1:0];
      if (w && a == A_DIV && $urandom_range(0, 3) != 0) w = 0;
      cycle(t, w, a, d, 1, r, q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
